aes256_ct_serializer: RTL
=========================

# aes256_ct_serializer

Parametrised ciphertext output stage for the AES-256 datapath: buffers up to DEPTH completed 128-bit ciphertext blocks from the encryption core. It streams them out OUT_W bits per beat over the `pi_next_val_req` / `po_next_val_ready` handshake. It generalises the fixed single-block, byte-wide output path with configurable beat width, multi-block buffering, selectable beat order, flush and occupancy reporting.

## Interface
Parameters:
- OUT_W, 8, output beat width in bits; legal values 8, 16, 32, 64, 128.
- DEPTH, 2, block buffer depth; power of two, ≥2.
- MSB_FIRST, 1, 1: beat 0 = bits [127:128-OUT_W]; 0: beat 0 = bits [OUT_W-1:0].

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  asynchronous active-low reset.
- pi_blk_valid  in  1  ciphertext block present on pi_blk.
- pi_blk  in  128  ciphertext block.
- po_blk_ready  out  1  buffer can accept a block.
- pi_flush  in  1  synchronous clear of all buffered data.
- pi_next_val_req  in  1  consumer requests the current beat.
- po_next_val_ready  out  1  po_data holds a valid beat.
- po_data  out  OUT_W  current beat.
- po_level  out  $clog2(DEPTH)+1  blocks currently buffered, including a partially drained one.
- po_last  out  1  present only with AES_SER_LAST_EN (see Configuration).

## Operation
- BEATS = 128/OUT_W. State: DEPTH×128 storage, write and read pointers, level counter, beat counter 0..BEATS-1.
- Push: pi_blk_valid && po_blk_ready at an edge writes pi_blk at the write pointer; wptr+1 mod DEPTH; level+1.
- po_blk_ready = (level != DEPTH). It does not depend on a same-cycle pop, so there is no combinational path from pi_next_val_req.
- po_next_val_ready = (level != 0). po_data = beat[beat_cnt] of the head block, selected per MSB_FIRST. po_data is forced to 0 when level == 0.
- Beat transfer: pi_next_val_req && po_next_val_ready at an edge. beat_cnt+1. On beat BEATS-1, beat_cnt wraps to 0, rptr+1 mod DEPTH, level-1.
- pi_next_val_req with level == 0 is ignored; no state change.
- Simultaneous push and last-beat pop: level unchanged; both pointers advance.
- OUT_W = 128: every transfer pops a block; beat_cnt stays 0.
- Flush: pi_flush at an edge zeroes pointers, level and beat_cnt. A same-edge push and transfer are discarded. Flush has priority.
- A partially drained block is never re-ordered. Pushes never overwrite the head block.

## Timing
- Reset (rst low, asynchronous): pointers, level, beat_cnt = 0. Outputs: po_blk_ready=1, po_next_val_ready=0, po_data=0, po_level=0, po_last=0. Storage is not reset.
- Reset mid-stream drops all buffered and partial blocks. First push is accepted at the first edge after rst rises.
- Push-to-output latency: a block pushed at edge N is visible on po_next_val_ready/po_data in the cycle after edge N. There is no same-cycle bypass.
- Sustained throughput: one beat per cycle while pi_next_val_req stays high and level>0. There are no bubbles between blocks.
- po_level updates one edge after the push or pop that causes it.

## Configuration
- AES_SER_LAST_EN defined: adds port po_last (out, 1). po_last = po_next_val_ready && beat_cnt == BEATS-1. It is 0 on reset, flush and when empty.
- AES_SER_LAST_EN undefined: the po_last port and its logic are absent. All other behaviour is identical.

## Test plan
- OUT_W=8, MSB_FIRST=1: push 128'h00112233445566778899AABBCCDDEEFF, hold pi_next_val_req=1 -> 16 consecutive beats 00,11,22,…,FF. po_level goes 1 -> 0 after the 16th beat. With the macro, po_last=1 only on FF.
- Same block with MSB_FIRST=0 -> beats FF,EE,…,11,00. OUT_W=32, MSB_FIRST=1 -> beats 00112233, 44556677, 8899AABB, CCDDEEFF.
- DEPTH=2, no requests: push A, B -> po_blk_ready=0, po_level=2. A third push C is held and not written. Drain one full block -> po_blk_ready=1 the next cycle, C accepted, output order A, B, C.
- Full buffer, push and last-beat pop on the same edge: push is rejected because po_blk_ready=0, head pops, po_level goes 2 -> 1. At level 1, push and last-beat pop on the same edge -> po_level stays 1, next beat is beat 0 of the new block.
- Flush after 5 beats of block A with B buffered, push asserted on the same edge -> po_level=0, po_next_val_ready=0, po_data=0. The next pushed block starts at beat 0.
- Assert rst low after 3 beats -> all outputs immediately at reset values. After release, push D -> first beat is D beat 0, one cycle after the push edge.

Source files
------------

// File: rtl/aes256_ct_serializer.sv
// Ciphertext output stage: buffers up to DEPTH 128-bit blocks and streams them out OUT_W bits per beat.
// Optional po_last beat marker is built only when AES_SER_LAST_EN is defined.
module aes256_ct_serializer #(
   parameter int OUT_W     = 8,
   parameter int DEPTH     = 2,
   parameter int MSB_FIRST = 1
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    pi_blk_valid,
   input  logic [127:0]            pi_blk,
   output logic                    po_blk_ready,
   input  logic                    pi_flush,
   input  logic                    pi_next_val_req,
   output logic                    po_next_val_ready,
   output logic [OUT_W-1:0]        po_data,
   output logic [$clog2(DEPTH):0]  po_level
`ifdef AES_SER_LAST_EN
   ,output logic                   po_last
`endif
);

   localparam int BEATS = 128 / OUT_W;
   localparam int PW    = $clog2(DEPTH);
   localparam int LW    = PW + 1;
   localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;

   // Handshakes: a block moves when pi_blk_valid && po_blk_ready at a rising edge;
   // a beat moves when pi_next_val_req && po_next_val_ready at a rising edge.
   logic [127:0]     r_mem [DEPTH];
   logic [PW-1:0]    r_wptr;
   logic [PW-1:0]    r_rptr;
   logic [LW-1:0]    r_level;
   logic [BW-1:0]    r_beat;

   logic             w_push;
   logic             w_xfer;
   logic             w_last_beat;
   logic             w_pop;
   logic [127:0]     w_head;
   logic [6:0]       w_lo;
   logic [OUT_W-1:0] w_beat_sel;

   assign po_blk_ready      = (r_level != LW'(DEPTH));
   assign po_next_val_ready = (r_level != '0);
   assign w_push            = pi_blk_valid && po_blk_ready;
   assign w_xfer            = pi_next_val_req && po_next_val_ready;
   assign w_last_beat       = (r_beat == BW'(BEATS - 1));
   assign w_pop             = w_xfer && w_last_beat;
   assign w_head            = r_mem[r_rptr];

   always_comb begin
      w_lo = '0;
      if (MSB_FIRST != 0) begin
         w_lo = 7'((BEATS - 1 - int'(r_beat)) * OUT_W);
      end else begin
         w_lo = 7'(int'(r_beat) * OUT_W);
      end
      w_beat_sel = w_head[w_lo +: OUT_W];
   end

   assign po_data  = po_next_val_ready ? w_beat_sel : '0;
   assign po_level = r_level;

`ifdef AES_SER_LAST_EN
   assign po_last = po_next_val_ready && w_last_beat;
`endif

   // Storage is intentionally left unreset; the level counter guards every read.
   always_ff @(posedge clk) begin
      if (w_push && !pi_flush) begin
         r_mem[r_wptr] <= pi_blk;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_level <= '0;
         r_beat  <= '0;
      end else if (pi_flush) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_level <= '0;
         r_beat  <= '0;
      end else begin
         if (w_push) begin
            r_wptr <= r_wptr + 1'b1;
         end
         if (w_xfer) begin
            if (w_last_beat) begin
               r_beat <= '0;
               r_rptr <= r_rptr + 1'b1;
            end else begin
               r_beat <= r_beat + 1'b1;
            end
         end
         if (w_push && !w_pop) begin
            r_level <= r_level + 1'b1;
         end else if (!w_push && w_pop) begin
            r_level <= r_level - 1'b1;
         end
      end
   end

endmodule
